// File: rtl/mips_mem_pkg.sv
// Shared constants for the cache-line refill/write-back interface.
// Used by the line memory here and by the L1 cache controller.
package mips_mem_pkg;

    localparam int LINE_BITS        = 128;
    localparam int LINE_OFFSET_BITS = 4;
    localparam int WORD_BITS        = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'b00;
    localparam state_t ST_BUSY    = 2'b01;
    localparam state_t ST_RESPOND = 2'b10;
    localparam state_t ST_RELEASE = 2'b11;

    function automatic int words_per_line(input int line_bits);
        return line_bits / WORD_BITS;
    endfunction

endpackage

// File: rtl/mips_line_ram.sv
// Line storage: DEPTH x WIDTH array, synchronous write, combinational read.
module mips_line_ram #(
    parameter int WIDTH  = 128,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; contents survive a reset and
    // clearing it would turn the RAM into a huge bank of resettable flops.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips_line_memory.sv
// Main-memory responder for line refills and write-backs: fixed latency,
// one-cycle mem_ready pulse, then a release phase until valid_mem drops.
module mips_line_memory #(
    parameter int LINE_BITS   = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_mem,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] address_to_mem,
    input  logic [LINE_BITS-1:0]  data_to_mem,
    output logic                  mem_ready,
    output logic [LINE_BITS-1:0]  data_from_mem,
    output logic                  mem_busy
);

    import mips_mem_pkg::state_t;
    import mips_mem_pkg::ST_IDLE;
    import mips_mem_pkg::ST_BUSY;
    import mips_mem_pkg::ST_RESPOND;
    import mips_mem_pkg::ST_RELEASE;
    import mips_mem_pkg::LINE_OFFSET_BITS;

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]     req_idx;
    logic [LINE_BITS-1:0] ram_rdata;
    logic                 ram_we;

    // Only the line index matters; high bits alias and the byte offset is ignored.
    assign req_idx = address_to_mem[IDX_W+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{address_to_mem[ADDR_WIDTH-1:IDX_W+LINE_OFFSET_BITS],
                                address_to_mem[LINE_OFFSET_BITS-1:0]};

    // NOTE: every always_comb output gets a hold default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_mem) begin
                    idx_d   = req_idx;
                    wr_d    = mem_write;
                    wdata_d = data_to_mem;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESPOND;
                    if (!wr_q) begin
                        rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Holding here until valid_mem falls keeps a held request from being served twice.
                if (!valid_mem) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The write commits on the edge leaving RESPOND, before IDLE can take a new request.
    assign ram_we = (state_q == ST_RESPOND) && wr_q;

    mips_line_ram #(
        .WIDTH (LINE_BITS),
        .DEPTH (DEPTH_LINES),
        .ADDR_W(IDX_W)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign mem_ready     = (state_q == ST_RESPOND);
    assign mem_busy      = (state_q != ST_IDLE);
    assign data_from_mem = rdata_q;

endmodule
